// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and instruction-RAM signal bundle for imem_port_arbiter
//   fetch : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   loader: l_req, l_we, l_addr, l_wdata, l_lock -> l_gnt, l_rvalid, l_rdata
//   memory: m_en, m_we, m_idx, m_wdata <- m_rdata
//   slave modport is the arbiter side; master modport is the requester/RAM side.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              m_en;
    logic              m_we;
    logic [IDX_W-1:0]  m_idx;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
               m_en, m_we, m_idx, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
               m_en, m_we, m_idx, m_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - two-way arbiter and sequencer for a single-port 256-word instruction RAM
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : fetch / loader / memory signals (slave side)
//   addr_err    : one-cycle pulse after a grant with a misaligned or out-of-range address
//   f_stall_cnt : saturating count of cycles where fetch requested but was not granted
module imem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_port_arbiter_if.slave   bus,
    output logic                 addr_err,
    output logic [15:0]          f_stall_cnt
);
    localparam logic [1:0] RD_NONE  = 2'd0;
    localparam logic [1:0] RD_FETCH = 2'd1;
    localparam logic [1:0] RD_LOAD  = 2'd2;

    localparam logic WIN_FETCH  = 1'b0;
    localparam logic WIN_LOADER = 1'b1;

    logic [1:0]        rd_tag;
    logic [1:0]        rd_tag_nxt;
    logic              last_win;
    logic              contested;
    logic [ADDR_W-1:0] gnt_addr;
    logic              addr_bad;

    // Lock gives the loader the memory outright; otherwise a contested cycle
    // goes to whoever did not win the previous contested cycle.
    always_comb begin
        bus.f_gnt = 1'b0;
        bus.l_gnt = 1'b0;
        contested = 1'b0;
        if (bus.l_lock) begin
            bus.l_gnt = bus.l_req;
        end else if (bus.f_req && bus.l_req) begin
            contested = 1'b1;
            if (last_win == WIN_LOADER) begin
                bus.f_gnt = 1'b1;
            end else begin
                bus.l_gnt = 1'b1;
            end
        end else begin
            bus.f_gnt = bus.f_req;
            bus.l_gnt = bus.l_req;
        end
    end

    // With no grant the fetch address still drives m_idx; m_en qualifies it.
    assign gnt_addr    = bus.l_gnt ? bus.l_addr : bus.f_addr;
    assign bus.m_idx   = gnt_addr[IDX_W+1:2];
    assign bus.m_en    = bus.f_gnt | bus.l_gnt;
    assign bus.m_we    = bus.l_gnt & bus.l_we;
    assign bus.m_wdata = bus.l_wdata;

    assign addr_bad = (gnt_addr[1:0] != 2'b00) || (gnt_addr[ADDR_W-1:IDX_W+2] != '0);

    always_comb begin
        rd_tag_nxt = RD_NONE;
        if (bus.f_gnt) begin
            rd_tag_nxt = RD_FETCH;
        end else if (bus.l_gnt && !bus.l_we) begin
            rd_tag_nxt = RD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag      <= RD_NONE;
            last_win    <= WIN_LOADER;
            addr_err    <= 1'b0;
            f_stall_cnt <= 16'd0;
        end else begin
            rd_tag   <= rd_tag_nxt;
            addr_err <= bus.m_en && addr_bad;
            if (contested) begin
                last_win <= bus.f_gnt ? WIN_FETCH : WIN_LOADER;
            end
            if (bus.f_req && !bus.f_gnt && (f_stall_cnt != 16'hFFFF)) begin
                f_stall_cnt <= f_stall_cnt + 16'd1;
            end
        end
    end

    // RAM data is shared by both returns; the rvalid tag says whose it is.
    assign bus.f_rvalid = (rd_tag == RD_FETCH);
    assign bus.l_rvalid = (rd_tag == RD_LOAD);
    assign bus.f_rdata  = bus.m_rdata;
    assign bus.l_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed-vector bench for imem_port_arbiter with a write-first RAM model
module tb_imem_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic        addr_err;
    logic [15:0] f_stall_cnt;

    int n_vec;
    int n_err;

    logic [31:0] mem [0:255];

    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .IDX_W(8)) bus ();

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IDX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .addr_err    (addr_err),
        .f_stall_cnt (f_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i * 3);
    endfunction

    // Write-first single-port RAM
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                mem[bus.m_idx] <= bus.m_wdata;
                bus.m_rdata    <= bus.m_wdata;
            end else begin
                bus.m_rdata    <= mem[bus.m_idx];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.l_req   = 1'b0;
        bus.l_we    = 1'b0;
        bus.l_addr  = '0;
        bus.l_wdata = '0;
        bus.l_lock  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        bus.m_rdata = '0;
        rst_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        check("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        check("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_stall", 32'(f_stall_cnt), 32'd0);

        // Fetch only: 0x0, 0x4, 0x8
        for (int k = 0; k < 3; k++) begin
            bus.f_req  = 1'b1;
            bus.f_addr = 32'(k * 4);
            #1;
            check($sformatf("fo_gnt%0d", k), 32'(bus.f_gnt), 32'd1);
            check($sformatf("fo_idx%0d", k), 32'(bus.m_idx), 32'(k));
            check($sformatf("fo_mwe%0d", k), 32'(bus.m_we), 32'd0);
            if (k > 0) begin
                check($sformatf("fo_rv%0d", k), 32'(bus.f_rvalid), 32'd1);
                check($sformatf("fo_rd%0d", k), bus.f_rdata, init_word(k - 1));
            end
            tick();
        end
        bus.f_req = 1'b0;
        #1;
        check("fo_rv3", 32'(bus.f_rvalid), 32'd1);
        check("fo_rd3", bus.f_rdata, init_word(2));
        check("fo_men_idle", 32'(bus.m_en), 32'd0);
        tick();
        check("fo_rv_end", 32'(bus.f_rvalid), 32'd0);

        // Contention after reset: F,L,F,L
        do_reset();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h8;
        bus.l_req  = 1'b1;
        bus.l_we   = 1'b0;
        bus.l_addr = 32'hC;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("ct_fgnt%0d", k), 32'(bus.f_gnt), 32'((k % 2) == 0));
            check($sformatf("ct_lgnt%0d", k), 32'(bus.l_gnt), 32'((k % 2) == 1));
            check($sformatf("ct_idx%0d", k), 32'(bus.m_idx), ((k % 2) == 0) ? 32'd2 : 32'd3);
            if (k > 0) begin
                check($sformatf("ct_frv%0d", k), 32'(bus.f_rvalid), 32'((k % 2) == 1));
                check($sformatf("ct_lrv%0d", k), 32'(bus.l_rvalid), 32'((k % 2) == 0));
            end
            if (k == 2) check("ct_lrd2", bus.l_rdata, init_word(3));
            tick();
        end
        idle_inputs();
        #1;
        check("ct_lrv4", 32'(bus.l_rvalid), 32'd1);
        check("ct_lrd4", bus.l_rdata, init_word(3));
        check("ct_stall", 32'(f_stall_cnt), 32'd2);

        // Program load under lock, then fetch of the written word next cycle
        bus.l_lock  = 1'b1;
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 32'h10;
        bus.l_wdata = 32'hDEADBEEF;
        bus.f_req   = 1'b1;
        bus.f_addr  = 32'h10;
        #1;
        check("pl_fgnt", 32'(bus.f_gnt), 32'd0);
        check("pl_lgnt", 32'(bus.l_gnt), 32'd1);
        check("pl_mwe", 32'(bus.m_we), 32'd1);
        check("pl_idx", 32'(bus.m_idx), 32'd4);
        check("pl_wdata", bus.m_wdata, 32'hDEADBEEF);
        tick();
        bus.l_lock = 1'b0;
        bus.l_req  = 1'b0;
        bus.l_we   = 1'b0;
        #1;
        check("pl_stall", 32'(f_stall_cnt), 32'd3);
        check("pl_no_lrv", 32'(bus.l_rvalid), 32'd0);
        check("pl_fgnt2", 32'(bus.f_gnt), 32'd1);
        tick();
        bus.f_req = 1'b0;
        #1;
        check("pl_frv", 32'(bus.f_rvalid), 32'd1);
        check("pl_frd", bus.f_rdata, 32'hDEADBEEF);
        tick();

        // Misaligned and out of range: 0x402 -> index 0x00
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h402;
        #1;
        check("ae_gnt", 32'(bus.f_gnt), 32'd1);
        check("ae_idx", 32'(bus.m_idx), 32'h00);
        check("ae_pre", 32'(addr_err), 32'd0);
        tick();
        bus.f_req = 1'b0;
        #1;
        check("ae_pulse", 32'(addr_err), 32'd1);
        check("ae_frv", 32'(bus.f_rvalid), 32'd1);
        check("ae_frd", bus.f_rdata, init_word(0));
        tick();
        check("ae_clear", 32'(addr_err), 32'd0);

        // Out of range only (aligned): 0x400 also flags
        bus.l_req  = 1'b1;
        bus.l_addr = 32'h400;
        tick();
        bus.l_req = 1'b0;
        #1;
        check("ae_range", 32'(addr_err), 32'd1);
        check("ae_lrv", 32'(bus.l_rvalid), 32'd1);
        tick();

        // Reset mid-read: contested fetch win leaves last_win=FETCH, then reset
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h8;
        bus.l_req  = 1'b1;
        bus.l_addr = 32'hC;
        #1;
        check("rr_fgnt", 32'(bus.f_gnt), 32'd1);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rr_frv", 32'(bus.f_rvalid), 32'd0);
        check("rr_stall", 32'(f_stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        check("rr_no_rv", 32'(bus.f_rvalid), 32'd0);
        bus.f_req = 1'b1;
        bus.l_req = 1'b1;
        #1;
        check("rr_first_f", 32'(bus.f_gnt), 32'd1);
        check("rr_first_l", 32'(bus.l_gnt), 32'd0);
        tick();

        // Saturation of the stall counter under lock
        do_reset();
        bus.l_lock = 1'b1;
        bus.f_req  = 1'b1;
        #1;
        check("sat_lock_fgnt", 32'(bus.f_gnt), 32'd0);
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", 32'(f_stall_cnt), 32'h0000FFFE);
        for (int i = 0; i < 70000 - 65534; i++) tick();
        check("sat_ffff", 32'(f_stall_cnt), 32'h0000FFFF);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
